// File: rtl/m_store_lane_buffer_pkg.sv
// rtl/m_store_lane_buffer_pkg.sv - store op codes, split FSM states and size decode
package m_store_lane_buffer_pkg;

   localparam logic [2:0] BEOP_NONE = 3'd0;
   localparam logic [2:0] BEOP_SB   = 3'd1;
   localparam logic [2:0] BEOP_SH   = 3'd2;
   localparam logic [2:0] BEOP_SW   = 3'd3;
   localparam logic [2:0] BEOP_SD   = 3'd4;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_SECOND = 1'b1
   } state_t;

   // Store size in bytes; 0 means "no store" (none, unknown code, or sd on a 32-bit lane).
   function automatic logic [3:0] beop_size(input logic [2:0] op, input int data_w);
      logic [3:0] s;
      case (op)
         BEOP_SB: s = 4'd1;
         BEOP_SH: s = 4'd2;
         BEOP_SW: s = 4'd4;
         BEOP_SD: s = (data_w == 64) ? 4'd8 : 4'd0;
         default: s = 4'd0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/m_beat_fifo.sv
// rtl/m_beat_fifo.sv - synchronous beat FIFO, registered full so pops never unblock a same-cycle push
module m_beat_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  store [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = empty ? '0 : store[rd_ptr];

   // Pointer/count update; pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) store[i] <= '0;
      end else begin
         if (do_push) begin
            store[wr_ptr] <= push_data;
            wr_ptr        <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/m_store_lane_buffer.sv
// rtl/m_store_lane_buffer.sv - M-stage store lane shifter, boundary splitter and beat queue
module m_store_lane_buffer
   import m_store_lane_buffer_pkg::*;
#(
   parameter int DATA_W        = 32,
   parameter int DEPTH         = 4,
   parameter int MISALIGN_MODE = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [31:0]         req_addr,
   input  logic [2:0]          req_op,
   input  logic [DATA_W-1:0]   req_data,
   output logic                mem_valid,
   input  logic                mem_ready,
   output logic [31:0]         mem_addr,
   output logic [DATA_W/8-1:0] mem_byteen,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic                ades,
   output logic                empty
);

   localparam int B     = DATA_W / 8;
   localparam int OFF_W = $clog2(B);
   localparam int EW    = 32 + B + DATA_W;

   state_t              state;
   state_t              state_next;
   logic [OFF_W-1:0]    off;
   logic [3:0]          req_size;
   logic                misaligned;
   logic [DATA_W-1:0]   data_m;
   logic [2*B-1:0]      en_src;
   logic [2*DATA_W-1:0] wdata_wide;
   logic [2*B-1:0]      en_wide;
   logic [31:0]         base_addr;
   logic                crosses;
   logic [EW-1:0]       beat1;
   logic [EW-1:0]       beat2_q;
   logic [EW-1:0]       push_data;
   logic                push;
   logic                latch_b2;
   logic                ades_set;
   logic                fifo_full;
   logic                fifo_empty;
   logic [EW-1:0]       head;

   assign off        = req_addr[OFF_W-1:0];
   assign req_size   = beop_size(req_op, DATA_W);
   assign misaligned = |(4'(off) & (req_size - 4'd1));
   assign base_addr  = {req_addr[31:OFF_W], {OFF_W{1'b0}}};

   // Keep only the S source bytes and build an S-byte enable mask before shifting into lane position.
   always_comb begin
      data_m = '0;
      en_src = '0;
      for (int i = 0; i < B; i++) begin
         if (i < int'(req_size)) begin
            data_m[i*8 +: 8] = req_data[i*8 +: 8];
            en_src[i]        = 1'b1;
         end
      end
   end

   // A double-width shift puts lane-overflow bytes in the upper half, which is exactly beat 2.
   assign wdata_wide = {{DATA_W{1'b0}}, data_m} << {off, 3'b000};
   assign en_wide    = en_src << off;
   assign crosses    = |en_wide[2*B-1:B];
   assign beat1      = {base_addr, en_wide[B-1:0], wdata_wide[DATA_W-1:0]};

   // Split FSM state register.
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // Accept, push and split decisions; SECOND blocks new requests until beat 2 is queued.
   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      push       = 1'b0;
      push_data  = beat1;
      latch_b2   = 1'b0;
      ades_set   = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = !fifo_full;
            if (req_valid && !fifo_full && req_size != 4'd0) begin
               if (misaligned && MISALIGN_MODE == 0) begin
                  ades_set = 1'b1;
               end else begin
                  push = 1'b1;
                  if (crosses) begin
                     latch_b2   = 1'b1;
                     state_next = ST_SECOND;
                  end
               end
            end
         end
         ST_SECOND: begin
            push_data = beat2_q;
            if (!fifo_full) begin
               push       = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Beat 2 holding register and the registered address-error pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         beat2_q <= '0;
         ades    <= 1'b0;
      end else begin
         if (latch_b2)
            beat2_q <= {base_addr + 32'(B), en_wide[2*B-1:B], wdata_wide[2*DATA_W-1:DATA_W]};
         ades <= ades_set;
      end
   end

   m_beat_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (mem_ready),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign mem_valid                          = !fifo_empty;
   assign {mem_addr, mem_byteen, mem_wdata}  = head;
   assign empty                              = fifo_empty && (state == ST_IDLE);

endmodule
